// File: rtl/sd_reader_pkg.sv
// Shared types and constants for the SD multi-block read path.
package sd_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_READY,
      READING,
      DRAIN,
      ERROR
   } state_t;

   localparam int unsigned SD_BLOCK_BYTES     = 512;
   // 100 ms of idle time at 25 MHz
   localparam int unsigned SD_DEFAULT_TIMEOUT = 2500000;

endpackage

// File: rtl/sd_byte_fifo.sv
// First-word fall-through byte FIFO with synchronous flush and occupancy output.
// The output register counts toward the level, so a write into an empty FIFO
// appears on rd_valid one cycle after the write edge.
module sd_byte_fifo #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                       clk_25mhz,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       rd_ready,
   output logic [7:0]                 rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] mem_cnt;
   logic          push;
   logic          pop;
   logic          load;

   assign level = mem_cnt + LW'(rd_valid);
   assign full  = (level == LW'(DEPTH));
   assign push  = wr_en && !full;
   assign pop   = rd_valid && rd_ready;
   assign load  = (mem_cnt != '0) && (!rd_valid || pop);

   // Storage array: written on push, no reset needed
   always_ff @(posedge clk_25mhz) begin
      if (push && !flush)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers, count and the fall-through output stage
   always_ff @(posedge clk_25mhz) begin
      if (!rst_n || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (load) begin
            rd_data  <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
            rd_valid <= 1'b1;
         end else if (pop) begin
            rd_valid <= 1'b0;
         end
         mem_cnt <= mem_cnt + LW'(push) - LW'(load);
      end
   end

endmodule

// File: rtl/sd_multiblock_reader.sv
// Multi-block SD read sequencer: issues one controller read per block,
// buffers bytes in a FWFT FIFO and streams them out with valid/ready.
// Build option SD_BYTE_ADDR_EN: byte addressing (address += BLOCK_BYTES per
// block, SDSC); otherwise block addressing (address += 1, SDHC).
module sd_multiblock_reader
   import sd_reader_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES    = SD_BLOCK_BYTES,
   parameter int unsigned FIFO_DEPTH     = 1024,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned NB_W           = 16,
   parameter int unsigned TIMEOUT_CYCLES = SD_DEFAULT_TIMEOUT
) (
   input  logic                          clk_25mhz,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             start_addr,
   input  logic [NB_W-1:0]               num_blocks,
   input  logic                          abort,
   input  logic                          ctrl_ready,
   output logic                          ctrl_rd,
   output logic [ADDR_W-1:0]             ctrl_address,
   input  logic [7:0]                    ctrl_dout,
   input  logic                          ctrl_byte_available,
   output logic [7:0]                    m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [NB_W-1:0]               blocks_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned LW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BC_W = $clog2(BLOCK_BYTES) + 1;
   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SD_BYTE_ADDR_EN
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BLOCK_BYTES);
`else
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`endif

   state_t          state, state_nxt;
   logic            prev_avail;
   logic [BC_W-1:0] byte_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [NB_W-1:0] nb_total;
   logic            fifo_full;
   logic [LW-1:0]   free_space;
   logic            strobe, tmo_hit;
   logic            issue, push, blk_end, flush, set_err, done_nxt, start_ok;

   assign strobe     = ctrl_byte_available && !prev_avail;
   assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign free_space = LW'(FIFO_DEPTH) - fifo_level;
   assign busy       = (state == WAIT_READY) || (state == READING) || (state == DRAIN);

   sd_byte_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_25mhz (clk_25mhz),
      .rst_n     (rst_n),
      .flush     (flush),
      .wr_en     (push),
      .wr_data   (ctrl_dout),
      .rd_ready  (m_ready),
      .rd_data   (m_data),
      .rd_valid  (m_valid),
      .level     (fifo_level),
      .full      (fifo_full)
   );

   // Next-state and per-cycle control strobes; abort overrides everything
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      push      = 1'b0;
      blk_end   = 1'b0;
      flush     = 1'b0;
      set_err   = 1'b0;
      done_nxt  = 1'b0;
      start_ok  = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
         flush     = 1'b1;
      end else begin
         case (state)
            IDLE, ERROR: begin
               if (start) begin
                  start_ok = 1'b1;
                  if (num_blocks != '0) begin
                     state_nxt = WAIT_READY;
                  end else begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            WAIT_READY: begin
               if (ctrl_ready && (free_space >= LW'(BLOCK_BYTES))) begin
                  issue     = 1'b1;
                  state_nxt = READING;
               end else if (tmo_hit) begin
                  set_err   = 1'b1;
                  flush     = 1'b1;
                  state_nxt = ERROR;
               end
            end
            READING: begin
               if (strobe) begin
                  if (fifo_full) begin
                     set_err   = 1'b1;
                     state_nxt = ERROR;
                  end else begin
                     push = 1'b1;
                     if (byte_cnt == BC_W'(BLOCK_BYTES - 1)) begin
                        blk_end   = 1'b1;
                        state_nxt = ((blocks_done + NB_W'(1)) == nb_total) ? DRAIN : WAIT_READY;
                     end
                  end
               end else if (tmo_hit) begin
                  set_err   = 1'b1;
                  flush     = 1'b1;
                  state_nxt = ERROR;
               end
            end
            DRAIN: begin
               if (fifo_level == '0) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register, transfer bookkeeping and registered outputs
   always_ff @(posedge clk_25mhz) begin
      if (!rst_n) begin
         state        <= IDLE;
         prev_avail   <= 1'b0;
         byte_cnt     <= '0;
         tmo_cnt      <= '0;
         nb_total     <= '0;
         ctrl_rd      <= 1'b0;
         ctrl_address <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         blocks_done  <= '0;
      end else begin
         state      <= state_nxt;
         prev_avail <= ctrl_byte_available;
         ctrl_rd    <= issue;
         done       <= done_nxt;
         if (start_ok) begin
            error       <= 1'b0;
            blocks_done <= '0;
            if (num_blocks != '0) begin
               ctrl_address <= start_addr;
               nb_total     <= num_blocks;
            end
         end
         if (set_err)
            error <= 1'b1;
         if (issue)
            byte_cnt <= '0;
         else if (push)
            byte_cnt <= byte_cnt + BC_W'(1);
         if (blk_end) begin
            ctrl_address <= ctrl_address + ADDR_STEP;
            if (blocks_done != nb_total)
               blocks_done <= blocks_done + NB_W'(1);
         end
         // Idle-time counter only runs while waiting on the controller
         if ((state_nxt != state) || push || !((state == WAIT_READY) || (state == READING)))
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_sd_multiblock_reader.sv
// Directed bench for sd_multiblock_reader: a cycle-stepped SD controller model
// streams bytes on a two-cycle strobe; each task checks its own scenario.
module tb_sd_multiblock_reader;

   localparam int BB  = 512;
   localparam int TMO = 1000;
`ifdef SD_BYTE_ADDR_EN
   localparam int STEP = 512;
`else
   localparam int STEP = 1;
`endif

   logic        clk_25mhz = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_addr = '0;
   logic [15:0] num_blocks = '0;
   logic        abort = 1'b0;
   logic        ctrl_ready = 1'b1;
   logic        ctrl_rd;
   logic [31:0] ctrl_address;
   logic [7:0]  sd_dout = '0;
   logic        sd_avail = 1'b0;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        busy, done, error;
   logic [15:0] blocks_done;
   logic [10:0] fifo_level;

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   int mdl_active, mdl_idx, mdl_blk, mdl_sent, mdl_limit, mdl_last_cyc, done_cnt;
   logic [7:0]  rx_q[$];
   logic [31:0] rd_q[$];
   int          lvl_q[$];

   always #20 clk_25mhz = ~clk_25mhz;

   sd_multiblock_reader #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_25mhz           (clk_25mhz),
      .rst_n               (rst_n),
      .start               (start),
      .start_addr          (start_addr),
      .num_blocks          (num_blocks),
      .abort               (abort),
      .ctrl_ready          (ctrl_ready),
      .ctrl_rd             (ctrl_rd),
      .ctrl_address        (ctrl_address),
      .ctrl_dout           (sd_dout),
      .ctrl_byte_available (sd_avail),
      .m_data              (m_data),
      .m_valid             (m_valid),
      .m_ready             (m_ready),
      .busy                (busy),
      .done                (done),
      .error               (error),
      .blocks_done         (blocks_done),
      .fifo_level          (fifo_level)
   );

   function automatic logic [7:0] pat(input int blk, input int i);
      return 8'((i + blk * 37) & 255);
   endfunction

   task automatic reset_model();
      mdl_active = 0; mdl_idx = 0; mdl_blk = 0; mdl_sent = 0;
      mdl_limit = 1 << 30; mdl_last_cyc = 0; done_cnt = 0;
      sd_avail = 1'b0; ctrl_ready = 1'b1;
      rx_q.delete(); rd_q.delete(); lvl_q.delete();
   endtask

   // One clock: record the pop decided by current inputs, then observe and drive the controller model
   task automatic step();
      if (m_valid === 1'b1 && m_ready === 1'b1) rx_q.push_back(m_data);
      @(negedge clk_25mhz);
      cyc_n++;
      if (done === 1'b1) done_cnt++;
      if (ctrl_rd === 1'b1) begin
         rd_q.push_back(ctrl_address);
         lvl_q.push_back(int'(fifo_level));
         mdl_active = 1;
         mdl_idx = 0;
      end
      if (sd_avail) begin
         sd_avail = 1'b0;
      end else if (mdl_active != 0 && mdl_idx < BB && mdl_sent < mdl_limit) begin
         sd_dout = pat(mdl_blk, mdl_idx);
         sd_avail = 1'b1;
         mdl_idx++;
         mdl_sent++;
         mdl_last_cyc = cyc_n;
      end
      if (!sd_avail && mdl_active != 0 && mdl_idx == BB) begin
         mdl_active = 0;
         mdl_blk++;
      end
   endtask

   task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
      start_addr = a; num_blocks = n; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int g = 0;
      while (done_cnt == 0 && g < budget) begin step(); g++; end
      ok = (done_cnt != 0);
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({ctrl_rd, m_valid, busy, done, error} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 00000", {ctrl_rd, m_valid, busy, done, error});
      end
      checks++;
      if (ctrl_address !== 32'h0 || blocks_done !== 16'h0) begin
         errors++; $display("FAIL reset_counts: addr %0h blocks %0d required 0 0", ctrl_address, blocks_done);
      end
      checks++;
      if (fifo_level !== 11'd0 || m_data !== 8'h00) begin
         errors++; $display("FAIL reset_fifo: level %0d data %0h required 0 0", fifo_level, m_data);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_block();
      bit ok;
      int bad = -1;
      reset_model(); m_ready = 1'b1;
      pulse_start(32'h100, 16'd1);
      wait_done(3000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_done_timeout: got no done required done within 3000 cycles"); end
      foreach (rx_q[k]) if (bad < 0 && rx_q[k] !== pat(k / BB, k % BB)) bad = k;
      checks++;
      if (rx_q.size() != BB || bad >= 0) begin
         errors++; $display("FAIL single_stream: got %0d bytes first bad %0d required %0d bytes in order", rx_q.size(), bad, BB);
      end
      checks++;
      if (rd_q.size() != 1 || rd_q[0] !== 32'h100) begin
         errors++; $display("FAIL single_rd: got %0d reads first addr %0h required 1 read at 100", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx);
      end
      checks++;
      if (done_cnt != 1 || blocks_done !== 16'd1 || busy !== 1'b0) begin
         errors++; $display("FAIL single_end: done %0d blocks %0d busy %b required 1 1 0", done_cnt, blocks_done, busy);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int g = 0;
      int bad = -1;
      reset_model(); m_ready = 1'b0;
      pulse_start(32'h100, 16'd3);
      while (!(rd_q.size() >= 2 && fifo_level == 11'd1024) && g < 4000) begin step(); g++; end
      checks++;
      if (fifo_level !== 11'd1024 || rd_q.size() != 2) begin
         errors++; $display("FAIL bp_fill: level %0d reads %0d required 1024 2", fifo_level, rd_q.size());
      end
      for (int i = 0; i < 300; i++) begin
         if (i == 100) begin
            start_addr = 32'h999; num_blocks = 16'd5; start = 1'b1;
         end
         step();
         start = 1'b0;
      end
      checks++;
      if (rd_q.size() != 2 || busy !== 1'b1) begin
         errors++; $display("FAIL bp_withheld: reads %0d busy %b required 2 1", rd_q.size(), busy);
      end
      m_ready = 1'b1;
      wait_done(5000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_done_timeout: got no done required done within 5000 cycles"); end
      checks++;
      if (rd_q.size() != 3 || lvl_q.size() != 3 || lvl_q[2] > 512) begin
         errors++; $display("FAIL bp_third_rd: reads %0d level at third rd %0d required 3 and <=512", rd_q.size(), (lvl_q.size() > 2) ? lvl_q[2] : -1);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (k >= rd_q.size() || rd_q[k] !== 32'(32'h100 + k * STEP)) begin
            errors++; $display("FAIL bp_addr%0d: got %0h required %0h", k, (k < rd_q.size()) ? rd_q[k] : 32'hx, 32'h100 + k * STEP);
         end
      end
      foreach (rx_q[k]) if (bad < 0 && rx_q[k] !== pat(k / BB, k % BB)) bad = k;
      checks++;
      if (rx_q.size() != 3 * BB || bad >= 0) begin
         errors++; $display("FAIL bp_stream: got %0d bytes first bad %0d required %0d bytes in order", rx_q.size(), bad, 3 * BB);
      end
      checks++;
      if (blocks_done !== 16'd3 || done_cnt != 1 || ctrl_address !== 32'(32'h100 + 3 * STEP)) begin
         errors++; $display("FAIL bp_end: blocks %0d done %0d addr %0h required 3 1 %0h", blocks_done, done_cnt, ctrl_address, 32'h100 + 3 * STEP);
      end
   endtask

   task automatic test_zero_blocks();
      bit busy_seen = 1'b0;
      reset_model();
      pulse_start(32'h55, 16'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_done: done %b busy %b required 1 0", done, busy);
      end
      step();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse_len: done %b required 0", done); end
      repeat (20) begin step(); if (busy !== 1'b0) busy_seen = 1'b1; end
      checks++;
      if (rd_q.size() != 0 || busy_seen || done_cnt != 1) begin
         errors++; $display("FAIL zero_quiet: reads %0d busy_seen %b done %0d required 0 0 1", rd_q.size(), busy_seen, done_cnt);
      end
   endtask

   task automatic test_abort();
      bit ok;
      int g = 0;
      int bad = -1;
      reset_model(); m_ready = 1'b1;
      mdl_limit = BB + 200;
      pulse_start(32'h200, 16'd3);
      while (!(mdl_sent == BB + 200 && !sd_avail) && g < 4000) begin
         step(); g++;
         if (rd_q.size() == 2) m_ready = 1'b0;
      end
      step();
      checks++;
      if (fifo_level == 11'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL abort_pre: level %0d busy %b required nonzero 1", fifo_level, busy);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || fifo_level !== 11'd0 || m_valid !== 1'b0 || ctrl_rd !== 1'b0) begin
         errors++; $display("FAIL abort_flush: busy %b level %0d valid %b rd %b required 0 0 0 0", busy, fifo_level, m_valid, ctrl_rd);
      end
      repeat (50) step();
      checks++;
      if (done_cnt != 0 || rd_q.size() != 2) begin
         errors++; $display("FAIL abort_quiet: done %0d reads %0d required 0 2", done_cnt, rd_q.size());
      end
      reset_model(); m_ready = 1'b1;
      pulse_start(32'h300, 16'd1);
      wait_done(3000, ok);
      foreach (rx_q[k]) if (bad < 0 && rx_q[k] !== pat(k / BB, k % BB)) bad = k;
      checks++;
      if (!ok || rx_q.size() != BB || bad >= 0 || rd_q.size() != 1 || rd_q[0] !== 32'h300) begin
         errors++; $display("FAIL abort_restart: done %b bytes %0d bad %0d reads %0d required 1 %0d -1 1", ok, rx_q.size(), bad, rd_q.size(), BB);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int g = 0;
      reset_model(); m_ready = 1'b0;
      mdl_limit = 300;
      pulse_start(32'h10, 16'd2);
      while (!(mdl_sent == 300 && !sd_avail) && g < 2000) begin step(); g++; end
      while (cyc_n < mdl_last_cyc + TMO && g < 4000) begin step(); g++; end
      checks++;
      if (error !== 1'b0 || fifo_level !== 11'd300) begin
         errors++; $display("FAIL timeout_early: error %b level %0d required 0 300", error, fifo_level);
      end
      step();
      checks++;
      if (error !== 1'b1) begin errors++; $display("FAIL timeout_edge: error %b required 1", error); end
      checks++;
      if (busy !== 1'b0 || fifo_level !== 11'd0 || m_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_state: busy %b level %0d valid %b required 0 0 0", busy, fifo_level, m_valid);
      end
      repeat (20) step();
      checks++;
      if (error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: error %b required 1", error); end
      reset_model(); m_ready = 1'b1;
      pulse_start(32'h40, 16'd1);
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_restart: error %b busy %b required 0 1", error, busy);
      end
      wait_done(3000, ok);
      checks++;
      if (!ok || rx_q.size() != BB || rd_q.size() != 1 || rd_q[0] !== 32'h40) begin
         errors++; $display("FAIL timeout_recover: done %b bytes %0d reads %0d required 1 %0d 1", ok, rx_q.size(), rd_q.size(), BB);
      end
   endtask

   task automatic test_addr_step_and_reset();
      bit ok;
      int g = 0;
      reset_model(); m_ready = 1'b1;
      pulse_start(32'h0, 16'd2);
      wait_done(5000, ok);
      checks++;
      if (!ok || rd_q.size() != 2 || rd_q[0] !== 32'h0 || rd_q[1] !== 32'(STEP)) begin
         errors++; $display("FAIL addr_step: done %b reads %0d second addr %0h required 1 2 %0h", ok, rd_q.size(), (rd_q.size() > 1) ? rd_q[1] : 32'hx, STEP);
      end
      reset_model(); m_ready = 1'b0;
      pulse_start(32'h77, 16'd2);
      while (mdl_sent < 100 && g < 1000) begin step(); g++; end
      rst_n = 1'b0;
      step();
      checks++;
      if ({ctrl_rd, m_valid, busy, done, error} !== 5'b0 || ctrl_address !== 32'h0 ||
          blocks_done !== 16'h0 || fifo_level !== 11'd0 || m_data !== 8'h00) begin
         errors++; $display("FAIL midblock_reset: flags %b addr %0h blocks %0d level %0d data %0h required all 0",
                            {ctrl_rd, m_valid, busy, done, error}, ctrl_address, blocks_done, fifo_level, m_data);
      end
      rst_n = 1'b1;
      reset_model();
      step();
   endtask

   initial begin
      reset_model();
      test_reset();
      test_single_block();
      test_backpressure();
      test_zero_blocks();
      test_abort();
      test_timeout();
      test_addr_step_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_multiblock_reader.md
Name: sd_multiblock_reader

Overview:
Parametrised successor to the single-block SD read sequencer. Reads N consecutive blocks starting at a given address from the SPI-mode SD controller. The address auto-advances per block. Bytes are buffered in an internal FIFO and delivered on a valid/ready byte stream. Sits between the SD controller and the audio/data consumers; gains back-pressure, abort, timeout and progress reporting.

Parameters:
BLOCK_BYTES, 512, bytes per SD block
FIFO_DEPTH, 1024, byte FIFO entries; power of two, must be >= BLOCK_BYTES
ADDR_W, 32, controller address width
NB_W, 16, width of block count
TIMEOUT_CYCLES, 2500000, max idle cycles while waiting for ctrl_ready or the next byte (100 ms @ 25 MHz)

Ports:
clk_25mhz  in  1  sole clock
rst_n  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; starts a transfer when idle
start_addr  in  ADDR_W  first block address, sampled on start
num_blocks  in  NB_W  number of blocks, sampled on start
abort  in  1  cancels the transfer and flushes the FIFO
ctrl_ready  in  1  SD controller ready for a new read
ctrl_rd  out  1  one-cycle read request to the controller
ctrl_address  out  ADDR_W  current block address
ctrl_dout  in  8  byte from the controller
ctrl_byte_available  in  1  byte strobe (level; edge-detected here)
m_data  out  8  output byte
m_valid  out  1  m_data valid
m_ready  in  1  consumer accepts the byte
busy  out  1  high in any state except IDLE/ERROR
done  out  1  one-cycle pulse when all blocks have been read and drained
error  out  1  sticky; timeout or overflow
blocks_done  out  NB_W  completed block count
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, FIFO empty. All outputs 0: ctrl_rd, ctrl_address, m_valid, m_data, busy, done, error, blocks_done, fifo_level. Internal prev_byte_available=0. A reset mid-transfer discards everything.
- States: IDLE, WAIT_READY, READING, DRAIN, ERROR.
- IDLE: on start with num_blocks!=0 → latch start_addr/num_blocks, clear blocks_done and error → WAIT_READY. On start with num_blocks==0 → done pulse next cycle, stay IDLE. On start while busy → ignored.
- WAIT_READY: issue only when ctrl_ready=1 and FIFO free space >= BLOCK_BYTES. Then ctrl_rd=1 for exactly one cycle, byte_cnt=0 → READING.
- READING: byte accepted when ctrl_byte_available=1 and prev=0. The byte is written to the FIFO at that edge and byte_cnt is incremented.
  - On the BLOCK_BYTES-th byte: blocks_done++, ctrl_address += 1 (block addressing).
  - If blocks_done reaches num_blocks → DRAIN, else → WAIT_READY.
- DRAIN: when the FIFO is empty → done=1 for one cycle → IDLE.
- Timeout: a counter resets on every state change and every accepted byte. In WAIT_READY or READING, reaching TIMEOUT_CYCLES → error=1, FIFO flushed → ERROR.
- Overflow: a byte strobe with the FIFO full sets error, drops the byte and → ERROR. Unreachable under correct gating.
- ERROR: holds error=1 until the next start (restarts the transfer) or reset.
- abort: in any state, takes effect next edge → IDLE, FIFO flushed, ctrl_rd=0, no done. abort and start in the same cycle: abort wins, start ignored.
- FIFO: first-word fall-through. A write at edge k gives m_valid=1 after edge k+1 if the FIFO was empty. Pop occurs when m_valid&&m_ready. Simultaneous push and pop leave fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- ctrl_address wraps modulo 2^ADDR_W. blocks_done saturates at num_blocks.

Optional Feature:
SD_BYTE_ADDR_EN
- Defined: SDSC byte addressing; ctrl_address advances by BLOCK_BYTES per block.
- Undefined: SDHC block addressing; advances by 1.
- No other behavioural difference.

Decomposition:
- Package sd_reader_pkg: state enum (IDLE, WAIT_READY, READING, DRAIN, ERROR), SD_BLOCK_BYTES=512, default timeout constant.
- Sub-module sd_byte_fifo (parametrised FWFT FIFO with flush, level output).

Test Plan:
- start, addr=0x100, num_blocks=1, m_ready=1, model streams 512 bytes 0..255,0..255 → 512 bytes out in order; ctrl_rd pulses once with ctrl_address=0x100; done once; blocks_done=1.
- num_blocks=3, m_ready low for 2000 cycles, FIFO_DEPTH=1024 → second block read, third rd withheld until fifo_level<=512; all 1536 bytes correct; ctrl_address values 0x100/0x101/0x102.
- start with num_blocks=0 → done pulse one cycle later; ctrl_rd never asserted; busy stays 0.
- abort after byte 200 of block 2 → IDLE next cycle, fifo_level=0, m_valid=0, no done; a new start then works normally.
- Model stops after byte 300, TIMEOUT_CYCLES=1000 → error=1 exactly 1000 cycles after the last byte; state ERROR; FIFO empty.
- With SD_BYTE_ADDR_EN defined, 2 blocks from 0x0 → ctrl_address 0x0 then 0x200. Pulling rst_n low mid-block → all outputs 0 on the next edge.
